// File: rtl/axi_slave_mem_responder.sv
// AXI4 responder backed by a word-wide register array. The write engine
// (AW/W/B) and the read engine (AR/R) run independently against a
// one-write / one-read storage array. Requests with WRAP bursts or
// oversized beats complete with SLVERR. Beats that fall outside the array
// complete with DECERR.
module axi_slave_mem_responder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 4,
    parameter int MEM_DEPTH  = 256
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic [ID_WIDTH-1:0]       awid,
    input  logic [7:0]                awlen,
    input  logic [2:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wlast,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [1:0]                bresp,
    output logic [ID_WIDTH-1:0]       bid,
    input  logic                      arvalid,
    output logic                      arready,
    input  logic [ADDR_WIDTH-1:0]     araddr,
    input  logic [ID_WIDTH-1:0]       arid,
    input  logic [7:0]                arlen,
    input  logic [2:0]                arsize,
    input  logic [1:0]                arburst,
    output logic                      rvalid,
    input  logic                      rready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic [ID_WIDTH-1:0]       rid,
    output logic                      rlast,
    output logic [15:0]               wr_txn_cnt,
    output logic [15:0]               rd_txn_cnt
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int LG     = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    // Address of the following beat: INCR steps by the beat size, others hold.
    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a,
                                                         input logic [2:0] size,
                                                         input logic [1:0] burst);
        if (burst == 2'b01) next_addr = a + (ADDR_WIDTH'(1) << size);
        else                next_addr = a;
    endfunction

    // Beat address decodes beyond the end of the array.
    function automatic logic is_oor(input logic [ADDR_WIDTH-1:0] a);
        is_oor = ((a >> LG) >= ADDR_WIDTH'(MEM_DEPTH));
    endfunction

    // Array index of an in-range beat address.
    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] a);
        word_idx = a[IDX_W+LG-1:LG];
    endfunction

    // Request-level error: WRAP bursts and beats wider than the bus.
    function automatic logic req_bad(input logic [2:0] size, input logic [1:0] burst);
        req_bad = (burst == 2'b10) || (size > 3'(LG));
    endfunction

    // Burst response: DECERR outranks SLVERR, which outranks OKAY.
    function automatic logic [1:0] resp_of(input logic dec, input logic slv);
        if (dec)      resp_of = RESP_DECERR;
        else if (slv) resp_of = RESP_SLVERR;
        else          resp_of = RESP_OKAY;
    endfunction

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Write engine state
    logic [1:0]            w_state_r;
    logic                  awready_r, wready_r, bvalid_r;
    logic [1:0]            bresp_r;
    logic [ID_WIDTH-1:0]   bid_r, wid_r;
    logic [ADDR_WIDTH-1:0] waddr_r;
    logic [7:0]            wlen_r, wbeat_r;
    logic [2:0]            wsize_r;
    logic [1:0]            wburst_r;
    logic                  w_reqerr_r, w_dec_r, w_slv_r;
    logic [15:0]           wr_txn_cnt_r;

    logic w_hs_s, w_oor_s, w_last_beat_s, mem_we_s, w_dec_beat_s, w_slv_beat_s;

    assign w_hs_s        = wvalid && wready_r;
    assign w_oor_s       = is_oor(waddr_r);
    assign w_last_beat_s = (wbeat_r == wlen_r);
    assign mem_we_s      = w_hs_s && !w_reqerr_r && !w_oor_s;
    assign w_dec_beat_s  = !w_reqerr_r && w_oor_s;
    assign w_slv_beat_s  = (wlast != w_last_beat_s);

    // Write FSM: accept AW, absorb W beats, then hold B until accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_r    <= W_IDLE;
            awready_r    <= 1'b0;
            wready_r     <= 1'b0;
            bvalid_r     <= 1'b0;
            bresp_r      <= 2'b00;
            bid_r        <= '0;
            wid_r        <= '0;
            waddr_r      <= '0;
            wlen_r       <= 8'd0;
            wbeat_r      <= 8'd0;
            wsize_r      <= 3'd0;
            wburst_r     <= 2'b00;
            w_reqerr_r   <= 1'b0;
            w_dec_r      <= 1'b0;
            w_slv_r      <= 1'b0;
            wr_txn_cnt_r <= 16'd0;
        end else begin
            case (w_state_r)
                W_IDLE: begin
                    awready_r <= 1'b1;
                    if (awvalid && awready_r) begin
                        wid_r      <= awid;
                        waddr_r    <= awaddr;
                        wlen_r     <= awlen;
                        wsize_r    <= awsize;
                        wburst_r   <= awburst;
                        wbeat_r    <= 8'd0;
                        w_reqerr_r <= req_bad(awsize, awburst);
                        w_slv_r    <= req_bad(awsize, awburst);
                        w_dec_r    <= 1'b0;
                        awready_r  <= 1'b0;
                        wready_r   <= 1'b1;
                        w_state_r  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs_s) begin
                        waddr_r <= next_addr(waddr_r, wsize_r, wburst_r);
                        wbeat_r <= wbeat_r + 8'd1;
                        w_dec_r <= w_dec_r | w_dec_beat_s;
                        w_slv_r <= w_slv_r | w_slv_beat_s;
                        if (w_last_beat_s) begin
                            wready_r  <= 1'b0;
                            bvalid_r  <= 1'b1;
                            bresp_r   <= resp_of(w_dec_r | w_dec_beat_s, w_slv_r | w_slv_beat_s);
                            bid_r     <= wid_r;
                            w_state_r <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bvalid_r && bready) begin
                        bvalid_r     <= 1'b0;
                        wr_txn_cnt_r <= wr_txn_cnt_r + 16'd1;
                        awready_r    <= 1'b1;
                        w_state_r    <= W_IDLE;
                    end
                end
                default: begin
                    awready_r <= 1'b0;
                    wready_r  <= 1'b0;
                    bvalid_r  <= 1'b0;
                    w_state_r <= W_IDLE;
                end
            endcase
        end
    end

    // Storage write port: byte-enabled, contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem[word_idx(waddr_r)][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read engine state
    logic                  r_state_r;
    logic                  arready_r, rvalid_r, rlast_r;
    logic [DATA_WIDTH-1:0] rdata_r;
    logic [1:0]            rresp_r;
    logic [ID_WIDTH-1:0]   rid_r;
    logic [ADDR_WIDTH-1:0] raddr_r;
    logic [7:0]            rlen_r, rbeat_r;
    logic [2:0]            rsize_r;
    logic [1:0]            rburst_r;
    logic                  r_reqerr_r;
    logic [15:0]           rd_txn_cnt_r;

    logic                  ar_hs_s, r_hs_s, rd_err_s, rd_oor_s;
    logic [ADDR_WIDTH-1:0] rd_addr_s;
    logic [DATA_WIDTH-1:0] rd_mem_s, rd_beat_data_s;
    logic [1:0]            rd_beat_resp_s;

    assign ar_hs_s   = arvalid && arready_r;
    assign r_hs_s    = rvalid_r && rready;
    assign rd_addr_s = (r_state_r == R_IDLE) ? araddr : raddr_r;
    assign rd_err_s  = (r_state_r == R_IDLE) ? req_bad(arsize, arburst) : r_reqerr_r;
    assign rd_oor_s  = is_oor(rd_addr_s);
    assign rd_mem_s  = mem[word_idx(rd_addr_s)];

    // Data and response of the beat about to be loaded into the R registers.
    always_comb begin
        rd_beat_data_s = '0;
        rd_beat_resp_s = RESP_OKAY;
        if (rd_err_s) begin
            rd_beat_resp_s = RESP_SLVERR;
        end else if (rd_oor_s) begin
            rd_beat_resp_s = RESP_DECERR;
        end else begin
            rd_beat_data_s = rd_mem_s;
        end
    end

    // Read FSM: load beat 0 on AR accept, then the next beat on each R handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_r    <= R_IDLE;
            arready_r    <= 1'b0;
            rvalid_r     <= 1'b0;
            rlast_r      <= 1'b0;
            rdata_r      <= '0;
            rresp_r      <= 2'b00;
            rid_r        <= '0;
            raddr_r      <= '0;
            rlen_r       <= 8'd0;
            rbeat_r      <= 8'd0;
            rsize_r      <= 3'd0;
            rburst_r     <= 2'b00;
            r_reqerr_r   <= 1'b0;
            rd_txn_cnt_r <= 16'd0;
        end else begin
            case (r_state_r)
                R_IDLE: begin
                    arready_r <= 1'b1;
                    if (ar_hs_s) begin
                        rid_r      <= arid;
                        rlen_r     <= arlen;
                        rsize_r    <= arsize;
                        rburst_r   <= arburst;
                        r_reqerr_r <= req_bad(arsize, arburst);
                        raddr_r    <= next_addr(araddr, arsize, arburst);
                        rbeat_r    <= 8'd0;
                        rdata_r    <= rd_beat_data_s;
                        rresp_r    <= rd_beat_resp_s;
                        rlast_r    <= (arlen == 8'd0);
                        rvalid_r   <= 1'b1;
                        arready_r  <= 1'b0;
                        r_state_r  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs_s) begin
                        if (rlast_r) begin
                            rvalid_r     <= 1'b0;
                            rlast_r      <= 1'b0;
                            rd_txn_cnt_r <= rd_txn_cnt_r + 16'd1;
                            arready_r    <= 1'b1;
                            r_state_r    <= R_IDLE;
                        end else begin
                            rdata_r <= rd_beat_data_s;
                            rresp_r <= rd_beat_resp_s;
                            rlast_r <= ((rbeat_r + 8'd1) == rlen_r);
                            rbeat_r <= rbeat_r + 8'd1;
                            raddr_r <= next_addr(raddr_r, rsize_r, rburst_r);
                        end
                    end
                end
                default: begin
                    arready_r <= 1'b0;
                    rvalid_r  <= 1'b0;
                    r_state_r <= R_IDLE;
                end
            endcase
        end
    end

    assign awready    = awready_r;
    assign wready     = wready_r;
    assign bvalid     = bvalid_r;
    assign bresp      = bresp_r;
    assign bid        = bid_r;
    assign arready    = arready_r;
    assign rvalid     = rvalid_r;
    assign rdata      = rdata_r;
    assign rresp      = rresp_r;
    assign rid        = rid_r;
    assign rlast      = rlast_r;
    assign wr_txn_cnt = wr_txn_cnt_r;
    assign rd_txn_cnt = rd_txn_cnt_r;
endmodule

// File: tb/tb_axi_slave_mem_responder.sv
// Directed bench for axi_slave_mem_responder (32-bit data, 256 words).
// Word addresses 0x000..0x3FC are in range; 0x400 and above decode to DECERR.
module tb_axi_slave_mem_responder;
    logic        clk, rst_n;
    logic        awvalid, awready;
    logic [31:0] awaddr;
    logic [3:0]  awid;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        wvalid, wready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        bvalid, bready;
    logic [1:0]  bresp;
    logic [3:0]  bid;
    logic        arvalid, arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid, rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic [3:0]  rid;
    logic        rlast;
    logic [15:0] wr_txn_cnt, rd_txn_cnt;

    int checks   = 0;
    int failures = 0;

    axi_slave_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
        .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rid(rid),
        .rlast(rlast), .wr_txn_cnt(wr_txn_cnt), .rd_txn_cnt(rd_txn_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        awaddr = a; awlen = len; awsize = 3'd2; awburst = burst; awid = id;
        awvalid = 1'b1;
        while (!awready && n < 20) begin tick(); n++; end
        chk("aw_wait", awready, 1'b1);
        tick();
        awvalid = 1'b0;
    endtask

    task automatic w_send(input logic [31:0] d, input logic [3:0] s, input logic l);
        int n = 0;
        wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
        while (!wready && n < 20) begin tick(); n++; end
        chk("w_wait", wready, 1'b1);
        tick();
        wvalid = 1'b0;
    endtask

    task automatic b_recv(input string tag, input logic [1:0] resp, input logic [3:0] id);
        int n = 0;
        while (!bvalid && n < 20) begin tick(); n++; end
        chk({tag, "_bvalid"}, bvalid, 1'b1);
        chk({tag, "_bresp"}, bresp, resp);
        chk({tag, "_bid"}, bid, id);
        bready = 1'b1;
        tick();
        bready = 1'b0;
    endtask

    task automatic wr1(input string tag, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] resp);
        aw_send(a, 8'd0, 2'b01, 4'd1);
        w_send(d, 4'hF, 1'b1);
        b_recv(tag, resp, 4'd1);
    endtask

    task automatic ar_send(input logic [31:0] a, input logic [7:0] len,
                           input logic [1:0] burst, input logic [3:0] id);
        int n = 0;
        araddr = a; arlen = len; arsize = 3'd2; arburst = burst; arid = id;
        arvalid = 1'b1;
        while (!arready && n < 20) begin tick(); n++; end
        chk("ar_wait", arready, 1'b1);
        tick();
        arvalid = 1'b0;
    endtask

    task automatic r_recv(input string tag, input logic [31:0] d, input logic [1:0] resp,
                          input logic last, input logic [3:0] id);
        int n = 0;
        rready = 1'b1;
        while (!rvalid && n < 20) begin tick(); n++; end
        chk({tag, "_rvalid"}, rvalid, 1'b1);
        chk({tag, "_rdata"}, rdata, d);
        chk({tag, "_rresp"}, rresp, resp);
        chk({tag, "_rlast"}, rlast, last);
        chk({tag, "_rid"}, rid, id);
        tick();
        rready = 1'b0;
    endtask

    // Beat presented with rready low for one cycle first; must hold still.
    task automatic r_hold(input string tag, input logic [31:0] d, input logic last,
                          input logic [3:0] id);
        rready = 1'b0;
        chk({tag, "_rdata"}, rdata, d);
        chk({tag, "_rlast"}, rlast, last);
        tick();
        chk({tag, "_hold_rvalid"}, rvalid, 1'b1);
        chk({tag, "_hold_rdata"}, rdata, d);
        chk({tag, "_hold_rlast"}, rlast, last);
        chk({tag, "_hold_rid"}, rid, id);
        rready = 1'b1;
        tick();
        rready = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        awvalid = 1'b0; awaddr = 32'd0; awid = 4'd0; awlen = 8'd0; awsize = 3'd0; awburst = 2'b00;
        wvalid = 1'b0; wdata = 32'd0; wstrb = 4'h0; wlast = 1'b0; bready = 1'b0;
        arvalid = 1'b0; araddr = 32'd0; arid = 4'd0; arlen = 8'd0; arsize = 3'd0; arburst = 2'b00;
        rready = 1'b0;
        tick(); tick();
        chk("rst_awready", awready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_wrcnt", wr_txn_cnt, 16'd0);
        chk("rst_rdcnt", rd_txn_cnt, 16'd0);
        rst_n = 1'b1;
        chk("rel_awready_low", awready, 1'b0);
        tick();
        chk("rel_awready", awready, 1'b1);
        chk("rel_arready", arready, 1'b1);

        // 1: single write
        aw_send(32'h100, 8'd0, 2'b01, 4'd3);
        w_send(32'hABCD1234, 4'hF, 1'b1);
        chk("t1_bvalid_next", bvalid, 1'b1);
        b_recv("t1", 2'b00, 4'd3);
        chk("t1_wrcnt", wr_txn_cnt, 16'd1);

        // 2: single read
        ar_send(32'h100, 8'd0, 2'b01, 4'd5);
        chk("t2_rvalid_next", rvalid, 1'b1);
        r_recv("t2", 32'hABCD1234, 2'b00, 1'b1, 4'd5);
        chk("t2_rvalid_off", rvalid, 1'b0);
        chk("t2_rdcnt", rd_txn_cnt, 16'd1);

        // 3: INCR burst with partial strobe, read back with rready toggling
        wr1("t3_pre", 32'h28, 32'hFFFFFFFF, 2'b00);
        aw_send(32'h20, 8'd3, 2'b01, 4'd7);
        w_send(32'd1, 4'hF, 1'b0);
        w_send(32'd2, 4'hF, 1'b0);
        w_send(32'd3, 4'h3, 1'b0);
        w_send(32'd4, 4'hF, 1'b1);
        b_recv("t3_w", 2'b00, 4'd7);
        chk("t3_wrcnt", wr_txn_cnt, 16'd3);
        ar_send(32'h20, 8'd3, 2'b01, 4'd2);
        r_recv("t3_b0", 32'd1, 2'b00, 1'b0, 4'd2);
        r_hold("t3_b1", 32'd2, 1'b0, 4'd2);
        r_hold("t3_b2", 32'hFFFF0003, 1'b0, 4'd2);
        r_hold("t3_b3", 32'd4, 1'b1, 4'd2);
        chk("t3_rdcnt", rd_txn_cnt, 16'd2);

        // 4: DECERR, WRAP SLVERR, early wlast SLVERR
        wr1("t4_pre0", 32'h0, 32'h11111111, 2'b00);
        wr1("t4_pre40", 32'h40, 32'h22222222, 2'b00);
        wr1("t4_oor", 32'h400, 32'h55555555, 2'b11);
        aw_send(32'h40, 8'd1, 2'b10, 4'd4);
        w_send(32'h99999999, 4'hF, 1'b0);
        w_send(32'h88888888, 4'hF, 1'b1);
        b_recv("t4_wrap", 2'b10, 4'd4);
        aw_send(32'h60, 8'd1, 2'b01, 4'd6);
        w_send(32'h1, 4'hF, 1'b1);
        chk("t4_early_nob", bvalid, 1'b0);
        w_send(32'h2, 4'hF, 1'b0);
        chk("t4_early_b", bvalid, 1'b1);
        b_recv("t4_wlast", 2'b10, 4'd6);
        ar_send(32'h0, 8'd0, 2'b01, 4'd1);
        r_recv("t4_rd0", 32'h11111111, 2'b00, 1'b1, 4'd1);
        ar_send(32'h40, 8'd0, 2'b01, 4'd1);
        r_recv("t4_rd40", 32'h22222222, 2'b00, 1'b1, 4'd1);

        // 5: FIXED burst and a burst running off the end of the array
        ar_send(32'h100, 8'd2, 2'b00, 4'd6);
        r_recv("t5_f0", 32'hABCD1234, 2'b00, 1'b0, 4'd6);
        r_recv("t5_f1", 32'hABCD1234, 2'b00, 1'b0, 4'd6);
        r_recv("t5_f2", 32'hABCD1234, 2'b00, 1'b1, 4'd6);
        wr1("t5_pre", 32'h3FC, 32'hCAFEF00D, 2'b00);
        ar_send(32'h3FC, 8'd1, 2'b01, 4'd8);
        r_recv("t5_e0", 32'hCAFEF00D, 2'b00, 1'b0, 4'd8);
        r_recv("t5_e1", 32'h0, 2'b11, 1'b1, 4'd8);
        chk("t5_wrcnt", wr_txn_cnt, 16'd9);
        chk("t5_rdcnt", rd_txn_cnt, 16'd6);

        // 6a: reset in the middle of a read burst
        ar_send(32'h20, 8'd3, 2'b01, 4'd3);
        r_recv("t6_b0", 32'd1, 2'b00, 1'b0, 4'd3);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_rvalid", rvalid, 1'b0);
        chk("t6_rst_arready", arready, 1'b0);
        chk("t6_rst_rdcnt", rd_txn_cnt, 16'd0);
        chk("t6_rst_wrcnt", wr_txn_cnt, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("t6_rel_arready_low", arready, 1'b0);
        tick();
        chk("t6_rel_arready", arready, 1'b1);
        ar_send(32'h24, 8'd0, 2'b01, 4'd9);
        r_recv("t6_new", 32'd2, 2'b00, 1'b1, 4'd9);
        chk("t6_rdcnt", rd_txn_cnt, 16'd1);

        // 6b: B held while bready stays low
        aw_send(32'h80, 8'd0, 2'b01, 4'd9);
        w_send(32'h5A5A5A5A, 4'hF, 1'b1);
        for (int i = 0; i < 10; i++) begin
            chk("t6_hold_bvalid", bvalid, 1'b1);
            chk("t6_hold_bresp", bresp, 2'b00);
            chk("t6_hold_bid", bid, 4'd9);
            chk("t6_hold_awready", awready, 1'b0);
            tick();
        end
        b_recv("t6_b", 2'b00, 4'd9);
        chk("t6_wrcnt", wr_txn_cnt, 16'd1);
        tick();
        chk("t6_awready_back", awready, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
